// File: rtl/nested_loop_counter.sv
// ---------------------------------------------------------------------------
// nested_loop_counter
//
// Purpose
//   NDIM-deep nested loop counter for CNN loop nests (e.g. kx, ky, ch).
//   Per-level trip counts are latched when a start is accepted. Each ena
//   consumes the current index tuple and advances to the next one. Level 0 is
//   the innermost level. A one-cycle done pulse follows consumption of the
//   final tuple.
//
// Parameters
//   CW    width of each level's index and bound
//   NDIM  number of nested levels (1..8); level 0 is innermost
//
// Ports
//   clk      in   1        system clock, rising edge
//   rst      in   1        asynchronous reset, active-high
//   start    in   1        launch a new loop nest (sampled only in IDLE)
//   ena      in   1        consume current tuple / advance (ignored in IDLE)
//   cfg_max  in   NDIM*CW  per-level trip count, level i at [i*CW +: CW]
//   cnt      out  NDIM*CW  current index tuple, level i at [i*CW +: CW]
//   busy     out  1        high while running
//   last     out  1        high while running and cnt is the final tuple
//   done     out  1        one-cycle pulse after the final tuple is consumed
//   wrap     out  NDIM     per-level wrap pulse (only with NLC_WRAP_FLAG_EN)
//
// Configuration
//   NLC_WRAP_FLAG_EN : when defined, adds the registered wrap port. wrap[i]
//   pulses for one cycle after an ena edge on which level i rolled over.
//   This includes the final ena. When undefined, the port and its logic are
//   absent.
// ---------------------------------------------------------------------------
module nested_loop_counter #(
   parameter int CW   = 16,
   parameter int NDIM = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ena,
   input  logic [NDIM*CW-1:0] cfg_max,
   output logic [NDIM*CW-1:0] cnt,
   output logic               busy,
   output logic               last,
`ifdef NLC_WRAP_FLAG_EN
   output logic [NDIM-1:0]    wrap,
`endif
   output logic               done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]      state;
   logic [CW-1:0]   bound    [NDIM];
   logic [CW-1:0]   idx      [NDIM];
   logic [CW-1:0]   idx_next [NDIM];
   logic [NDIM-1:0] at_top;
   logic [NDIM-1:0] carry;
   logic            run;
   logic            adv;
   logic            fin;

   // A bound of 0 behaves like 1: the level is pinned at index 0.
   // The decrement only happens for a non-zero bound, so it cannot underflow.
   function automatic logic [CW-1:0] top_of(input logic [CW-1:0] b);
      return (b == '0) ? '0 : (b - 1'b1);
   endfunction

   assign run  = (state == ST_RUN);
   assign adv  = run && ena;
   assign busy = run;
   assign last = run && (&at_top);
   assign fin  = adv && (&at_top);

   always_comb begin
      for (int i = 0; i < NDIM; i++) begin
         at_top[i] = (idx[i] == top_of(bound[i]));
      end
   end

   // Ripple carry: level i advances only when every inner level is at its top.
   always_comb begin
      carry = '0;
      carry[0] = adv;
      for (int i = 1; i < NDIM; i++) begin
         carry[i] = carry[i-1] && at_top[i-1];
      end
   end

   always_comb begin
      for (int i = 0; i < NDIM; i++) begin
         idx_next[i] = idx[i];
         if (carry[i]) begin
            idx_next[i] = at_top[i] ? '0 : (idx[i] + 1'b1);
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NDIM; i++) begin
         cnt[i*CW +: CW] = idx[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         done  <= 1'b0;
         for (int i = 0; i < NDIM; i++) begin
            bound[i] <= '0;
            idx[i]   <= '0;
         end
      end else begin
         done <= fin;
         case (state)
            ST_IDLE: begin
               // ena is ignored here, including in the cycle a start is taken.
               if (start) begin
                  state <= ST_RUN;
                  for (int i = 0; i < NDIM; i++) begin
                     bound[i] <= cfg_max[i*CW +: CW];
                     idx[i]   <= '0;
                  end
               end
            end
            ST_RUN: begin
               // start is ignored while running; the bounds stay as latched.
               if (fin) begin
                  state <= ST_IDLE;
                  for (int i = 0; i < NDIM; i++) begin
                     idx[i] <= '0;
                  end
               end else begin
                  for (int i = 0; i < NDIM; i++) begin
                     idx[i] <= idx_next[i];
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef NLC_WRAP_FLAG_EN
   // carry is only ever set while running, so no separate state qualifier is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap <= '0;
      end else begin
         wrap <= carry & at_top;
      end
   end
`endif

endmodule

// File: tb/tb_nested_loop_counter.sv
module tb_nested_loop_counter;
   localparam int CW   = 16;
   localparam int NDIM = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               ena;
   logic [NDIM*CW-1:0] cfg_max;
   logic [NDIM*CW-1:0] cnt;
   logic               busy;
   logic               last;
   logic               done;
`ifdef NLC_WRAP_FLAG_EN
   logic [NDIM-1:0]    wrap;
`endif

   int checks   = 0;
   int failures = 0;

   // Scoreboard of expected tuples, oldest first.
   logic [NDIM*CW-1:0] sb [$];

   always #5 clk = ~clk;

   nested_loop_counter #(.CW(CW), .NDIM(NDIM)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .ena     (ena),
      .cfg_max (cfg_max),
      .cnt     (cnt),
      .busy    (busy),
      .last    (last),
`ifdef NLC_WRAP_FLAG_EN
      .wrap    (wrap),
`endif
      .done    (done)
   );

   function automatic logic [NDIM*CW-1:0] tup(input int a2, input int a1, input int a0);
      logic [NDIM*CW-1:0] t;
      t = '0;
      t[2*CW +: CW] = CW'(a2);
      t[1*CW +: CW] = CW'(a1);
      t[0*CW +: CW] = CW'(a0);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch a nest (ena held high during the start cycle, which must be ignored),
   // then consume every tuple. With gaps, ena follows the pattern 1,1,0 repeating.
   // On return the bench is in the done cycle.
   task automatic run_nest(input logic [NDIM*CW-1:0] cfg, input bit gaps, input string tag);
      int e [NDIM];
      int prod [NDIM];
      int total;
      int n_ena;
      int cyc;
      bit en;
      logic [NDIM*CW-1:0] exp;
      for (int i = 0; i < NDIM; i++) begin
         e[i] = (cfg[i*CW +: CW] == '0) ? 1 : int'(cfg[i*CW +: CW]);
         prod[i] = (i == 0) ? e[0] : prod[i-1] * e[i];
      end
      total = prod[NDIM-1];
      for (int n = 0; n < total; n++) begin
         sb.push_back(tup((n / (e[0] * e[1])) % e[2], (n / e[0]) % e[1], n % e[0]));
      end
      start = 1'b1; ena = 1'b1; cfg_max = cfg;
      tick();
      start = 1'b0; ena = 1'b0;
      chk({tag, "_busy_after_start"}, 64'(busy), 64'(1));
      chk({tag, "_cnt_after_start"}, 64'(cnt), 64'(0));
      chk({tag, "_done_after_start"}, 64'(done), 64'(0));
      n_ena = 0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 1000) begin
         en = !gaps || (cyc % 3 != 2);
         ena = en;
         chk({tag, "_last"}, 64'(last), 64'(sb.size() == 1));
         chk({tag, "_busy_run"}, 64'(busy), 64'(1));
         if (en) begin
            exp = sb.pop_front();
         end else begin
            exp = sb[0];
         end
         chk({tag, "_cnt"}, 64'(cnt), 64'(exp));
         tick();
         cyc++;
         if (en) n_ena++;
`ifdef NLC_WRAP_FLAG_EN
         for (int i = 0; i < NDIM; i++) begin
            chk($sformatf("%s_wrap%0d", tag, i), 64'(wrap[i]),
                64'(en && (n_ena % prod[i] == 0)));
         end
`endif
         if (sb.size() > 0) chk({tag, "_done_early"}, 64'(done), 64'(0));
      end
      ena = 1'b0;
      if (sb.size() > 0) begin
         chk({tag, "_timeout_remaining"}, 64'(sb.size()), 64'(0));
         sb.delete();
      end
      chk({tag, "_done"}, 64'(done), 64'(1));
      chk({tag, "_busy_end"}, 64'(busy), 64'(0));
      chk({tag, "_cnt_end"}, 64'(cnt), 64'(0));
      chk({tag, "_last_end"}, 64'(last), 64'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ena = 1'b0; cfg_max = '0;

      // Power-on reset.
      repeat (10) tick();
      chk("rst_cnt", 64'(cnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      rst = 1'b0;
      tick();
      chk("post_rst_cnt", 64'(cnt), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
      chk("post_rst_done", 64'(done), 64'(0));
      chk("post_rst_last", 64'(last), 64'(0));

      // Reset asserted in the middle of a run takes effect immediately.
      start = 1'b1; cfg_max = tup(2, 3, 4);
      tick();
      start = 1'b0; ena = 1'b1;
      repeat (5) tick();
      chk("mid_cnt_before_rst", 64'(cnt), 64'(tup(0, 1, 1)));
      ena = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_cnt", 64'(cnt), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_last", 64'(last), 64'(0));
`ifdef NLC_WRAP_FLAG_EN
      chk("mid_rst_wrap", 64'(wrap), 64'(0));
`endif
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Full nest {2,3,4}, ena held high: 24 tuples in order.
      run_nest(tup(2, 3, 4), 1'b0, "full");
      tick();
      chk("full_done_pulse_end", 64'(done), 64'(0));
      tick();

      // Same nest with ena gaps.
      run_nest(tup(2, 3, 4), 1'b1, "gaps");
      tick();
      chk("gaps_done_pulse_end", 64'(done), 64'(0));

      // Single tuple nest {1,0,1}; a start during the run must be ignored.
      start = 1'b1; cfg_max = tup(1, 0, 1);
      tick();
      start = 1'b0;
      chk("one_busy", 64'(busy), 64'(1));
      chk("one_last", 64'(last), 64'(1));
      start = 1'b1; cfg_max = tup(2, 3, 4);
      tick();
      start = 1'b0;
      chk("one_restart_busy", 64'(busy), 64'(1));
      chk("one_restart_last", 64'(last), 64'(1));
      chk("one_restart_cnt", 64'(cnt), 64'(0));
      chk("one_restart_done", 64'(done), 64'(0));
      ena = 1'b1;
      tick();
      ena = 1'b0;
      chk("one_done", 64'(done), 64'(1));
      chk("one_busy_end", 64'(busy), 64'(0));
`ifdef NLC_WRAP_FLAG_EN
      chk("one_wrap", 64'(wrap), 64'(3'b111));
`endif

      // Back-to-back nest: start driven in the done cycle.
      run_nest(tup(1, 1, 5), 1'b0, "b2b");
      tick();
      chk("b2b_done_pulse_end", 64'(done), 64'(0));
      chk("b2b_idle_busy", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit; normal completion is far earlier.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end
endmodule
